i2s_tx: RTL and testbench

I2S serial transmitter for the DAC path. It consumes the LRCK/SCLK pair produced by the on-chip I2S clock generator, which runs in the same mclk_in domain. It accepts stereo sample pairs through a valid/ready handshake and drives standard Philips-I2S serial data: MSB first, one SCLK delay after each LRCK edge, left channel while LRCK=0. A one-pair holding buffer decouples the sample source from frame timing, and an underrun flag reports frames with no data.

---
 rtl/i2s_tx.sv | 112 +++++++++++
 tb/tb_i2s_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : Philips-I2S serial transmitter with a one-pair holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  arstn_in,
  input  logic                  mclk_in,
  input  logic                  lrck_in,
  input  logic                  sclk_in,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  sdata_out,
  output logic                  underrun_out
);

  localparam int c_PAD_WIDTH = SLOT_WIDTH - DATA_WIDTH;

  logic                  r_sclk_q;
  logic                  r_lrck_q;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_buf_left;
  logic [DATA_WIDTH-1:0] r_buf_right;
  logic [DATA_WIDTH-1:0] r_right_hold;
  logic [SLOT_WIDTH-1:0] r_shreg;
  logic                  r_sdata;
  logic                  r_underrun;

  logic w_fall;
  logic w_lrck_chg;
  logic w_frame_start;
  logic w_right_start;
  logic w_accept;

  // LRCK transitions only count when they line up with an SCLK falling edge.
  assign w_fall        = r_sclk_q & ~sclk_in;
  assign w_lrck_chg    = w_fall & (lrck_in != r_lrck_q);
  assign w_frame_start = w_lrck_chg & ~lrck_in;
  assign w_right_start = w_lrck_chg & lrck_in;
  assign w_accept      = valid_in & ~r_full;

  assign ready_out    = ~r_full;
  assign sdata_out    = r_sdata;
  assign underrun_out = r_underrun;

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_sclk_q <= 1'b0;
      r_lrck_q <= 1'b0;
    end else begin
      r_sclk_q <= sclk_in;
      r_lrck_q <= lrck_in;
    end
  end

  // Accept only happens while empty, so it never collides with a consuming frame start.
  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_full      <= 1'b0;
      r_buf_left  <= '0;
      r_buf_right <= '0;
    end else if (w_accept) begin
      r_full      <= 1'b1;
      r_buf_left  <= left_in;
      r_buf_right <= right_in;
    end else if (w_frame_start) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_shreg      <= '0;
      r_right_hold <= '0;
    end else if (w_frame_start) begin
      if (r_full) begin
        r_shreg      <= {r_buf_left, {c_PAD_WIDTH{1'b0}}};
        r_right_hold <= r_buf_right;
      end else begin
        r_shreg      <= '0;
        r_right_hold <= '0;
      end
    end else if (w_right_start) begin
      r_shreg <= {r_right_hold, {c_PAD_WIDTH{1'b0}}};
    end else if (w_fall) begin
      r_shreg <= r_shreg << 1;
    end
  end

  // The slot-boundary fall emits the one-SCLK I2S delay bit.
  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start & ~r_full;
      if (w_lrck_chg) begin
        r_sdata <= 1'b0;
      end else if (w_fall) begin
        r_sdata <= r_shreg[SLOT_WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Purpose  : Self-checking bench for i2s_tx against a frame-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

  localparam int DW = 24;
  localparam int SW = 32;

  logic          mclk_in  = 1'b0;
  logic          arstn_in = 1'b0;
  logic          lrck_in  = 1'b0;
  logic          sclk_in  = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] left_in  = '0;
  logic [DW-1:0] right_in = '0;
  logic          ready_out;
  logic          sdata_out;
  logic          underrun_out;

  // Clock generator state: MCLK_DIV_SCLK=4, MCLK_DIV_LRCK=256.
  logic [7:0] cnt = 8'd20;

  i2s_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .arstn_in    (arstn_in),
    .mclk_in     (mclk_in),
    .lrck_in     (lrck_in),
    .sclk_in     (sclk_in),
    .left_in     (left_in),
    .right_in    (right_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .sdata_out   (sdata_out),
    .underrun_out(underrun_out)
  );

  always #5 mclk_in = ~mclk_in;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [31:0]   exp_l;
    logic [31:0]   exp_r;
  } vec_t;

  // Reference model: pending-pair queue and the words of the current frame.
  pair_t         pend[$];
  logic [DW-1:0] cur_l = '0;
  logic [DW-1:0] cur_r = '0;
  bit            m_live = 0, m_under = 0, m_acc = 0, armed = 0;
  logic [31:0]   cap = '0, last_l = '0, last_r = '0;
  logic [7:0]    last_c = '0;
  int            errors = 0, checks = 0, n_under = 0, n_ones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bits the DAC sees in one slot: delay bit, sample MSB first, zero fill.
  function automatic logic [31:0] slot_word(input logic [DW-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < DW; k++) s[SW-2-k] = w[DW-1-k];
    return s;
  endfunction

  task automatic model_step();
    bit can_acc;
    pair_t p;
    m_acc   = 0;
    m_under = 0;
    if (!arstn_in) begin
      pend.delete();
      cur_l  = '0;
      cur_r  = '0;
      m_live = 0;
      armed  = 0;
    end else begin
      can_acc = (pend.size() == 0);
      if (m_live && cnt == 8'd0) begin
        if (pend.size() > 0) begin
          p     = pend.pop_front();
          cur_l = p.l;
          cur_r = p.r;
        end else begin
          cur_l   = '0;
          cur_r   = '0;
          m_under = 1;
        end
      end
      if (valid_in && can_acc) begin
        p.l = left_in;
        p.r = right_in;
        pend.push_back(p);
        m_acc = 1;
      end
      m_live = 1;
    end
  endtask

  task automatic tick();
    @(negedge mclk_in);
    model_step();
    chk("ready_out", {31'd0, ready_out}, {31'd0, pend.size() == 0});
    chk("underrun_out", {31'd0, underrun_out}, {31'd0, m_under});
    if (underrun_out) n_under++;
    if (sdata_out) n_ones++;
    if (cnt[1:0] == 2'd2) begin
      if (cnt[6:2] == 5'd0) armed = arstn_in;
      cap = {cap[30:0], sdata_out};
      if (cnt[6:2] == 5'd31 && armed) begin
        if (cnt[7]) begin
          chk("right_slot", cap, slot_word(cur_r));
          last_r = cap;
        end else begin
          chk("left_slot", cap, slot_word(cur_l));
          last_l = cap;
        end
      end
    end
    last_c  = cnt;
    cnt     = cnt + 8'd1;
    sclk_in = cnt[1];
    lrck_in = cnt[7];
  endtask

  task automatic wait_c(input logic [7:0] t);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (last_c != t && k < 600);
    chk("wait_bound", {24'd0, last_c}, {24'd0, t});
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit keep);
    int k;
    k        = 0;
    valid_in = 1'b1;
    left_in  = l;
    right_in = r;
    do begin
      tick();
      k++;
    end while (!m_acc && k < 600);
    chk("accept_bound", {31'd0, m_acc}, 32'd1);
    if (!keep) valid_in = 1'b0;
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{l: 24'hA5A5A5, r: 24'h123456, exp_l: 32'h52D2D280, exp_r: 32'h091A2B00};
    tbl[1] = '{l: 24'h7FFFFF, r: 24'h800000, exp_l: 32'h3FFFFF80, exp_r: 32'h40000000};
    tbl[2] = '{l: 24'hFFFFFF, r: 24'h000001, exp_l: 32'h7FFFFF80, exp_r: 32'h00000080};
    tbl[3] = '{l: 24'h800001, r: 24'h7FFFFE, exp_l: 32'h40000080, exp_r: 32'h3FFFFF00};

    // Reset state
    repeat (5) tick();
    chk("rst_sdata", {31'd0, sdata_out}, 32'd0);
    chk("rst_underrun", {31'd0, underrun_out}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    arstn_in = 1'b1;
    n_under  = 0;
    wait_c(8'd255);
    chk("no_underrun_before_first_frame", n_under, 0);
    wait_c(8'd254);

    // Table-driven single pairs, each checked in the frame that follows
    for (int i = 0; i < 4; i++) begin
      push(tbl[i].l, tbl[i].r, 0);
      n_under = 0;
      wait_c(8'd0);
      wait_c(8'd254);
      chk("tbl_left", last_l, tbl[i].exp_l);
      chk("tbl_right", last_r, tbl[i].exp_r);
      chk("tbl_no_underrun", n_under, 0);
    end

    // valid_in held high across two distinct pairs
    wait_c(8'd10);
    push(24'h5A5A5A, 24'h3C3C3C, 1);
    left_in  = 24'h0F0F0F;
    right_in = 24'hC3C3C3;
    tick();
    chk("hold_ready_low", {31'd0, ready_out}, 32'd0);
    push(24'h0F0F0F, 24'hC3C3C3, 0);
    chk("second_accept_cnt", {24'd0, last_c}, 32'd1);
    n_under = 0;
    wait_c(8'd254);
    chk("b2b_first_left", last_l, 32'h2D2D2D00);
    chk("b2b_first_right", last_r, 32'h1E1E1E00);
    wait_c(8'd254);
    chk("b2b_second_left", last_l, 32'h07878780);
    chk("b2b_second_right", last_r, 32'h61E1E180);
    chk("b2b_no_underrun", n_under, 0);

    // Three empty frames
    n_under = 0;
    n_ones  = 0;
    repeat (768) tick();
    chk("underrun_3_frames", n_under, 3);
    chk("idle_sdata_zero", n_ones, 0);

    // Accept in the exact cycle of an empty frame start
    wait_c(8'd255);
    valid_in = 1'b1;
    left_in  = 24'h7FFFFF;
    right_in = 24'h800000;
    tick();
    valid_in = 1'b0;
    chk("fs_accept_underrun", {31'd0, underrun_out}, 32'd1);
    chk("fs_accept_ready", {31'd0, ready_out}, 32'd0);
    wait_c(8'd254);
    n_under = 0;
    wait_c(8'd254);
    chk("fs_accept_left", last_l, 32'h3FFFFF80);
    chk("fs_accept_right", last_r, 32'h40000000);
    chk("fs_accept_no_underrun", n_under, 0);

    // Reset during bit 10 of a left slot with a second pair buffered
    wait_c(8'd10);
    push(24'hFFFFFF, 24'hFFFFFF, 0);
    wait_c(8'd0);
    push(24'h333333, 24'h444444, 0);
    wait_c(8'd42);
    chk("pre_reset_sdata", {31'd0, sdata_out}, 32'd1);
    arstn_in = 1'b0;
    #1;
    chk("mid_rst_sdata", {31'd0, sdata_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_out}, 32'd1);
    chk("mid_rst_underrun", {31'd0, underrun_out}, 32'd0);
    repeat (3) tick();
    arstn_in = 1'b1;
    n_under  = 0;
    wait_c(8'd0);
    chk("post_rst_underrun", n_under, 1);
    wait_c(8'd254);
    chk("post_rst_left", last_l, 32'd0);
    chk("post_rst_right", last_r, 32'd0);

    // Randomised traffic against the reference model
    repeat (6 * 256) begin
      valid_in = ($urandom_range(0, 39) == 0);
      left_in  = DW'($urandom);
      right_in = DW'($urandom);
      tick();
    end
    valid_in = 1'b0;
    wait_c(8'd254);
    wait_c(8'd254);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
